// File: rtl/self_reloading_counter.sv
// Down-counter that reloads its stored value after reaching 0; load_i overrides and updates the reload value.
// count_o is registered (1-cycle latency from load); no backpressure. Optional wrap_o via SELF_RELOADING_COUNTER_WRAP_EN.
module self_reloading_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
`ifdef SELF_RELOADING_COUNTER_WRAP_EN
  output logic             wrap_o,
`endif
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] reload_val;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] reload_nxt;
  logic             at_zero;

  assign at_zero = (count == '0);

  // Load wins over both decrement and zero-reload; 0 reloads, so no underflow.
  always_comb begin
    count_nxt  = count - 1'b1;
    reload_nxt = reload_val;
    if (load_i) begin
      count_nxt  = load_val_i;
      reload_nxt = load_val_i;
    end else if (at_zero) begin
      count_nxt  = reload_val;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count      <= '1;
      reload_val <= '1;
    end else begin
      count      <= count_nxt;
      reload_val <= reload_nxt;
    end
  end

  assign count_o = count;

`ifdef SELF_RELOADING_COUNTER_WRAP_EN
  assign wrap_o = reset & at_zero & ~load_i;
`endif

endmodule

// File: tb/tb_self_reloading_counter.sv
// Directed and randomized checks of self_reloading_counter against an arithmetic reference model.
module tb_self_reloading_counter;
  localparam int W    = 4;
  localparam int ONES = (1 << W) - 1;

  logic         clk;
  logic         reset;
  logic         load_i;
  logic [W-1:0] load_val_i;
  logic [W-1:0] count_o;
`ifdef SELF_RELOADING_COUNTER_WRAP_EN
  logic         wrap_o;
`endif

  int tests;
  int fails;
  int m_count;
  int m_reload;

  self_reloading_counter #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load_i),
    .load_val_i (load_val_i),
`ifdef SELF_RELOADING_COUNTER_WRAP_EN
    .wrap_o     (wrap_o),
`endif
    .count_o    (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: period reload+1 down-count, load overrides, reset forces all-ones.
  task automatic model_edge(input logic ld, input int v);
    if (!reset) begin
      m_count  = ONES;
      m_reload = ONES;
    end else if (ld) begin
      m_count  = v;
      m_reload = v;
    end else if (m_count == 0) begin
      m_count = m_reload;
    end else begin
      m_count = m_count - 1;
    end
  endtask

  // Called just after a falling edge: drive inputs, check wrap, take the rising edge, check count.
  task automatic cycle(input logic ld, input int v);
    load_i     = ld;
    load_val_i = W'(v);
    #1;
`ifdef SELF_RELOADING_COUNTER_WRAP_EN
    check("wrap_model", int'(wrap_o), int'(reset && m_count == 0 && !ld));
`endif
    @(negedge clk);
    model_edge(ld, v);
    check("count_model", int'(count_o), m_count);
  endtask

  task automatic expect_lit(input string name, input int v);
    check(name, int'(count_o), v);
    check({name, "_model"}, m_count, v);
  endtask

  task automatic async_reset_pulse();
    #1 reset = 1'b0;
    #1;
    model_edge(1'b0, 0);
    check("async_rst_count", int'(count_o), m_count);
    reset = 1'b1;
  endtask

  initial begin
    int guard;
    tests      = 0;
    fails      = 0;
    m_count    = 0;
    m_reload   = 0;
    reset      = 1'b1;
    load_i     = 1'b0;
    load_val_i = '0;

    // Reset then run
    #1 reset = 1'b0;
    #1;
    model_edge(1'b0, 0);
    expect_lit("rst_F", 15);
`ifdef SELF_RELOADING_COUNTER_WRAP_EN
    check("rst_wrap", int'(wrap_o), 0);
`endif
    @(negedge clk);
    expect_lit("rst_hold_F", 15);
    reset = 1'b1;
    cycle(1'b0, 0); expect_lit("run_E", 14);
    cycle(1'b0, 0); expect_lit("run_D", 13);
    cycle(1'b0, 0); expect_lit("run_C", 12);

    // Load 5 and auto-reload
    cycle(1'b1, 5); expect_lit("ld5_5", 5);
    for (int i = 4; i >= 0; i--) begin
      cycle(1'b0, 0);
      expect_lit("ld5_down", i);
    end
`ifdef SELF_RELOADING_COUNTER_WRAP_EN
    #1 check("ld5_wrap_at0", int'(wrap_o), 1);
`endif
    cycle(1'b0, 0); expect_lit("ld5_reload", 5);
    cycle(1'b0, 0); expect_lit("ld5_4", 4);

    // Load mid-count
    cycle(1'b1, 12); expect_lit("ldC_C", 12);
    cycle(1'b0, 0);  expect_lit("ldC_B", 11);
    cycle(1'b0, 0);  expect_lit("ldC_A", 10);
    for (int i = 0; i < 10; i++) cycle(1'b0, 0);
    expect_lit("ldC_zero", 0);
    cycle(1'b0, 0);  expect_lit("ldC_reload", 12);

    // Load at zero
    guard = 0;
    while (m_count != 0 && guard < 40) begin
      cycle(1'b0, 0);
      guard++;
    end
    expect_lit("ld0_reach0", 0);
    cycle(1'b1, 3); expect_lit("ldz_3", 3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 0);
    expect_lit("ldz_0", 0);
    cycle(1'b0, 0); expect_lit("ldz_reload3", 3);

    // Asynchronous reset mid-count at 7
    cycle(1'b1, 9);
    cycle(1'b0, 0);
    cycle(1'b0, 0); expect_lit("ar_at7", 7);
    async_reset_pulse();
    expect_lit("ar_F", 15);
    cycle(1'b0, 0); expect_lit("ar_E", 14);
    cycle(1'b0, 0); expect_lit("ar_D", 13);
    for (int i = 0; i < 13; i++) cycle(1'b0, 0);
    expect_lit("ar_zero", 0);
    cycle(1'b0, 0); expect_lit("ar_reloadF", 15);

    // Zero load holds at 0
    cycle(1'b1, 0); expect_lit("zl_0", 0);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 0);
      expect_lit("zl_hold", 0);
    end
`ifdef SELF_RELOADING_COUNTER_WRAP_EN
    #1 check("zl_wrap", int'(wrap_o), 1);
`endif

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, 39));
      if (r == 0) begin
        async_reset_pulse();
      end else if (r == 1) begin
        #1 reset = 1'b0;
        #1;
        model_edge(1'b0, 0);
        check("rnd_rst", int'(count_o), m_count);
        cycle(1'b0, 0);
        reset = 1'b1;
      end
      if ($urandom_range(0, 7) == 0)
        cycle(1'b1, int'($urandom_range(0, ONES)));
      else
        cycle(1'b0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
